// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
// Shares a single-port, 1-cycle-read data RAM between the processor data port
// and a peripheral port. The processor wins by default. A peripheral request
// that has been denied STARVE_LIMIT consecutive cycles is forced through, and
// the processor is stalled for that one cycle.
//
// Ports:
//   clock, reset                 clock and asynchronous active-low reset
//   cpu_access/wren/addr/data    processor MEM-stage access
//   cpu_q, cpu_stall             processor read data (RAM passthrough), stall
//   p_req/we/addr/wdata          peripheral request, held until p_gnt
//   p_gnt, p_rvalid, p_rdata     peripheral grant and read response
//   ram_wEn/addr/dataIn/dataOut  RAM instance interface
//   stall_count                  saturating count of forced-stall cycles
module dmem_port_arbiter #(
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned STALL_CNT_W  = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cpu_access,
  input  logic                   cpu_wren,
  input  logic [ADDR_W-1:0]      cpu_addr,
  input  logic [DATA_W-1:0]      cpu_data,
  output logic [DATA_W-1:0]      cpu_q,
  output logic                   cpu_stall,
  input  logic                   p_req,
  input  logic                   p_we,
  input  logic [ADDR_W-1:0]      p_addr,
  input  logic [DATA_W-1:0]      p_wdata,
  output logic                   p_gnt,
  output logic                   p_rvalid,
  output logic [DATA_W-1:0]      p_rdata,
  output logic                   ram_wEn,
  output logic [ADDR_W-1:0]      ram_addr,
  output logic [DATA_W-1:0]      ram_dataIn,
  input  logic [DATA_W-1:0]      ram_dataOut,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam int unsigned WAIT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

  // Owner of the read data returning from the RAM on the next cycle.
  localparam logic [1:0] OWN_NONE   = 2'd0;
  localparam logic [1:0] OWN_CPU    = 2'd1;
  localparam logic [1:0] OWN_PERIPH = 2'd2;

  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_cnt_nxt;
  logic [1:0]        rd_owner;
  logic [1:0]        rd_owner_nxt;
  logic [DATA_W-1:0] p_rdata_q;
  logic              force_c;
  logic              p_sel_c;
  logic              cpu_sel_c;

  // Grant decision and RAM steering; everything is held quiet while in reset.
  always_comb begin
    force_c      = 1'b0;
    p_sel_c      = 1'b0;
    cpu_sel_c    = 1'b0;
    p_gnt        = 1'b0;
    cpu_stall    = 1'b0;
    ram_wEn      = 1'b0;
    ram_addr     = '0;
    ram_dataIn   = '0;
    wait_cnt_nxt = '0;
    rd_owner_nxt = OWN_NONE;

    if (reset) begin
      force_c   = p_req && cpu_access && (wait_cnt == WAIT_MAX);
      p_sel_c   = p_req && (!cpu_access || force_c);
      cpu_sel_c = cpu_access && !force_c;

      // Idle bus keeps the processor address on the RAM.
      ram_addr   = cpu_addr;
      ram_dataIn = cpu_data;
      if (p_sel_c) begin
        ram_wEn    = p_we;
        ram_addr   = p_addr;
        ram_dataIn = p_wdata;
      end else if (cpu_sel_c) begin
        ram_wEn = cpu_wren;
      end

      p_gnt     = p_sel_c;
      cpu_stall = force_c;

      // Count consecutive denied cycles of a pending peripheral request.
      if (p_req && !p_sel_c && (wait_cnt != WAIT_MAX)) begin
        wait_cnt_nxt = wait_cnt + WAIT_W'(1);
      end else if (p_req && !p_sel_c) begin
        wait_cnt_nxt = wait_cnt;
      end

      if (p_sel_c && !p_we) begin
        rd_owner_nxt = OWN_PERIPH;
      end else if (cpu_sel_c && !cpu_wren) begin
        rd_owner_nxt = OWN_CPU;
      end
    end
  end

  // Arbitration state and statistics.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt    <= '0;
      rd_owner    <= OWN_NONE;
      p_rdata_q   <= '0;
      stall_count <= '0;
    end else begin
      wait_cnt <= wait_cnt_nxt;
      rd_owner <= rd_owner_nxt;
      if (p_rvalid) begin
        p_rdata_q <= ram_dataOut;
      end
      if (force_c && (stall_count != {STALL_CNT_W{1'b1}})) begin
        stall_count <= stall_count + STALL_CNT_W'(1);
      end
    end
  end

  // Read data routing: peripheral sees live RAM data only in its response cycle.
  assign p_rvalid = (rd_owner == OWN_PERIPH);
  assign p_rdata  = p_rvalid ? ram_dataOut : p_rdata_q;
  assign cpu_q    = ram_dataOut;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

  localparam int unsigned ADDR_W       = 12;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned STARVE_LIMIT = 8;
  localparam int unsigned STALL_CNT_W  = 2;
  localparam int          STALL_MAX    = 3;

  logic                   clk;
  logic                   reset;
  logic                   cpu_access;
  logic                   cpu_wren;
  logic [ADDR_W-1:0]      cpu_addr;
  logic [DATA_W-1:0]      cpu_data;
  logic [DATA_W-1:0]      cpu_q;
  logic                   cpu_stall;
  logic                   p_req;
  logic                   p_we;
  logic [ADDR_W-1:0]      p_addr;
  logic [DATA_W-1:0]      p_wdata;
  logic                   p_gnt;
  logic                   p_rvalid;
  logic [DATA_W-1:0]      p_rdata;
  logic                   ram_wEn;
  logic [ADDR_W-1:0]      ram_addr;
  logic [DATA_W-1:0]      ram_dataIn;
  logic [DATA_W-1:0]      ram_dataOut;
  logic [STALL_CNT_W-1:0] stall_count;

  int checks   = 0;
  int failures = 0;

  dmem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .STARVE_LIMIT(STARVE_LIMIT), .STALL_CNT_W(STALL_CNT_W)
  ) dut (
    .clock(clk), .reset(reset),
    .cpu_access(cpu_access), .cpu_wren(cpu_wren), .cpu_addr(cpu_addr),
    .cpu_data(cpu_data), .cpu_q(cpu_q), .cpu_stall(cpu_stall),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_gnt(p_gnt), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
    .ram_wEn(ram_wEn), .ram_addr(ram_addr), .ram_dataIn(ram_dataIn),
    .ram_dataOut(ram_dataOut), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM instance stand-in: synchronous read of the old contents, 1-cycle latency.
  logic [DATA_W-1:0] ram_mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (ram_wEn) ram_mem[ram_addr] <= ram_dataIn;
    ram_dataOut <= ram_mem[ram_addr];
  end

  // Reference model state.
  logic [DATA_W-1:0] m_mem [0:(1<<ADDR_W)-1];
  int                m_denied = 0;
  int                m_stalls = 0;
  logic              m_rvalid = 1'b0;
  logic [DATA_W-1:0] m_resp   = '0;
  logic [DATA_W-1:0] m_hold   = '0;
  logic [DATA_W-1:0] m_q      = '0;
  logic              m_q_ok   = 1'b0;

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      ram_mem[i] = '0;
      m_mem[i]   = '0;
    end
    ram_dataOut = '0;
  end

  task automatic chk(input string name, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // The peripheral wins when the processor is idle or has starved it long enough.
  function automatic logic m_periph_wins();
    return reset && p_req && (!cpu_access || (m_denied >= STARVE_LIMIT));
  endfunction

  // Model advance: what the RAM sees this cycle and what comes back next cycle.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_denied = 0;
      m_stalls = 0;
      m_rvalid = 1'b0;
      m_resp   = '0;
      m_hold   = '0;
      m_q      = m_mem[0];
      m_q_ok   = 1'b0;
    end else begin
      logic              pw;
      logic              wen;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      pw  = m_periph_wins();
      a   = pw ? p_addr : cpu_addr;
      d   = pw ? p_wdata : cpu_data;
      wen = pw ? p_we : (cpu_access && cpu_wren);
      if (m_rvalid) m_hold = m_resp;
      m_q    = m_mem[a];
      m_q_ok = 1'b1;
      if (wen) m_mem[a] = d;
      m_rvalid = pw && !p_we;
      m_resp   = m_q;
      if (pw && cpu_access) m_stalls++;
      m_denied = (p_req && !pw) ? m_denied + 1 : 0;
    end
  end

  // Per-cycle comparison of every observable output against the model.
  always @(negedge clk) begin
    logic pw;
    pw = m_periph_wins();
    chk("p_gnt", 32'(p_gnt), 32'(pw));
    chk("cpu_stall", 32'(cpu_stall), 32'(pw && cpu_access));
    chk("ram_wEn", 32'(ram_wEn),
        32'(reset && (pw ? p_we : (cpu_access && cpu_wren))));
    chk("ram_addr", 32'(ram_addr), !reset ? 32'd0 : (pw ? 32'(p_addr) : 32'(cpu_addr)));
    if (reset && ram_wEn) chk("ram_dataIn", ram_dataIn, pw ? p_wdata : cpu_data);
    chk("p_rvalid", 32'(p_rvalid), 32'(m_rvalid));
    chk("p_rdata", p_rdata, m_rvalid ? m_resp : m_hold);
    if (m_q_ok) chk("cpu_q", cpu_q, m_q);
    chk("stall_count", 32'(stall_count),
        32'((m_stalls > STALL_MAX) ? STALL_MAX : m_stalls));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_access = 1'b0; cpu_wren = 1'b0; cpu_addr = '0; cpu_data = '0;
    p_req = 1'b0; p_we = 1'b0; p_addr = '0; p_wdata = '0;
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    step(); step();
    #2;
    chk("rst_p_rvalid", 32'(p_rvalid), 32'd0);
    chk("rst_p_gnt", 32'(p_gnt), 32'd0);
    chk("rst_stall_count", 32'(stall_count), 32'd0);
    reset = 1'b1;
    step();

    // Processor write then read of 0x010.
    cpu_access = 1'b1; cpu_wren = 1'b1; cpu_addr = 12'h010; cpu_data = 32'hDEADBEEF;
    #2 chk("cpu_wr_wen", 32'(ram_wEn), 32'd1);
    chk("cpu_wr_stall", 32'(cpu_stall), 32'd0);
    step();
    cpu_wren = 1'b0;
    #2 chk("cpu_rd_wen", 32'(ram_wEn), 32'd0);
    step();
    cpu_access = 1'b0;
    #2 chk("cpu_rd_q", cpu_q, 32'hDEADBEEF);

    // Peripheral read on an idle bus.
    p_req = 1'b1; p_we = 1'b0; p_addr = 12'h010;
    #2 chk("p_rd_gnt", 32'(p_gnt), 32'd1);
    step();
    p_req = 1'b0;
    #2 chk("p_rd_rvalid", 32'(p_rvalid), 32'd1);
    chk("p_rd_rdata", p_rdata, 32'hDEADBEEF);
    step();
    #2 chk("p_rd_rvalid_once", 32'(p_rvalid), 32'd0);
    chk("p_rd_rdata_held", p_rdata, 32'hDEADBEEF);

    // Starvation: 8 denied cycles, then a forced slot, twice.
    cpu_access = 1'b1; cpu_wren = 1'b0; cpu_addr = 12'h100;
    p_req = 1'b1; p_we = 1'b1; p_addr = 12'h020; p_wdata = 32'h12345678;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 8; i++) begin
        #2 chk("starve_denied", 32'(p_gnt), 32'd0);
        step();
      end
      #2 chk("starve_force_gnt", 32'(p_gnt), 32'd1);
      chk("starve_force_stall", 32'(cpu_stall), 32'd1);
      chk("starve_force_addr", 32'(ram_addr), 32'h020);
      step();
      #2 chk("starve_count", 32'(stall_count), 32'(r + 1));
      chk("starve_no_double_stall", 32'(cpu_stall), 32'd0);
    end
    idle_inputs();
    step();

    // Collision: CPU write first, peripheral write next cycle, read back.
    cpu_access = 1'b1; cpu_wren = 1'b1; cpu_addr = 12'h030; cpu_data = 32'hAAAA0000;
    p_req = 1'b1; p_we = 1'b1; p_addr = 12'h030; p_wdata = 32'h0000BBBB;
    #2 chk("coll_cpu_data", ram_dataIn, 32'hAAAA0000);
    chk("coll_cpu_pgnt", 32'(p_gnt), 32'd0);
    step();
    cpu_access = 1'b0; cpu_wren = 1'b0;
    #2 chk("coll_p_gnt", 32'(p_gnt), 32'd1);
    chk("coll_p_data", ram_dataIn, 32'h0000BBBB);
    step();
    p_we = 1'b0;
    step();
    p_req = 1'b0;
    #2 chk("coll_readback", p_rdata, 32'h0000BBBB);
    step();

    // Reset asserted while a peripheral read is outstanding.
    p_req = 1'b1; p_we = 1'b0; p_addr = 12'h010;
    #2 chk("rst_mid_gnt", 32'(p_gnt), 32'd1);
    #1 reset = 1'b0;
    #1 chk("rst_mid_rvalid", 32'(p_rvalid), 32'd0);
    chk("rst_mid_gnt_off", 32'(p_gnt), 32'd0);
    chk("rst_mid_wen", 32'(ram_wEn), 32'd0);
    chk("rst_mid_count", 32'(stall_count), 32'd0);
    idle_inputs();
    step();
    reset = 1'b1;
    step();
    #2 chk("rst_rel_rvalid", 32'(p_rvalid), 32'd0);
    step();
    #2 chk("rst_rel_rvalid2", 32'(p_rvalid), 32'd0);

    // Saturation: five forced events on a 2-bit counter, then one more.
    cpu_access = 1'b1; cpu_addr = 12'h200;
    p_req = 1'b1; p_we = 1'b0; p_addr = 12'h010;
    repeat (5 * (STARVE_LIMIT + 1)) step();
    #2 chk("sat_count", 32'(stall_count), 32'd3);
    repeat (STARVE_LIMIT + 1) step();
    #2 chk("sat_hold", 32'(stall_count), 32'd3);
    idle_inputs();
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port data RAM (12-bit address, 32-bit data, 1-cycle synchronous read) between two requesters: the processor data port and a peripheral port used by the audio/score logic.
- The processor has priority by default. A starvation counter forces a peripheral slot and stalls the processor for exactly one cycle.
- Sits between the processor/peripheral side and the RAM instance in the top-level wrapper.

Parameters:
- ADDR_W, 12, RAM address width.
- DATA_W, 32, RAM data width.
- STARVE_LIMIT, 8, number of consecutive cycles a pending peripheral request may be denied before a forced grant (must be ≥1).
- STALL_CNT_W, 16, width of the stall statistics counter.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_access  in  1  processor memory op (load or store) in MEM stage this cycle.
- cpu_wren  in  1  processor store.
- cpu_addr  in  ADDR_W  processor address.
- cpu_data  in  DATA_W  processor store data.
- cpu_q  out  DATA_W  read data to processor (RAM dataOut passthrough).
- cpu_stall  out  1  processor must hold MEM stage this cycle.
- p_req  in  1  peripheral request, held until granted.
- p_we  in  1  peripheral write.
- p_addr  in  ADDR_W  peripheral address, stable while p_req.
- p_wdata  in  DATA_W  peripheral write data, stable while p_req.
- p_gnt  out  1  peripheral access issued to RAM this cycle.
- p_rvalid  out  1  p_rdata valid (read grant, one cycle later).
- p_rdata  out  DATA_W  peripheral read data.
- ram_wEn  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_dataIn  out  DATA_W  RAM write data.
- ram_dataOut  in  DATA_W  RAM read data (valid one cycle after address).
- stall_count  out  STALL_CNT_W  saturating count of forced-stall cycles.

Behaviour:
- Reset (reset=0, asynchronous): wait_cnt=0, rd_owner=NONE, p_rvalid=0, p_rdata=0, stall_count=0. While reset is low, p_gnt=0, cpu_stall=0, ram_wEn=0, ram_addr=0, ram_dataIn=0.
- Per-cycle grant decision is combinational from inputs and wait_cnt. There are three cases:
  - CPU: cpu_access=1 and not forced. RAM is driven from the cpu_* inputs; p_gnt=0; cpu_stall=0.
  - PERIPH: cpu_access=0 and p_req=1. RAM is driven from the p_* inputs; p_gnt=1.
  - FORCE: p_req=1 and cpu_access=1 and wait_cnt==STARVE_LIMIT. RAM is driven from the p_* inputs; p_gnt=1; cpu_stall=1.
- If neither requester is active: ram_wEn=0, ram_addr holds the cpu_addr value, p_gnt=0.
- Simultaneous CPU and peripheral writes: the CPU write wins unless forced. The peripheral write is never dropped; it stays pending.
- wait_cnt, registered:
  - Increments when p_req=1 and p_gnt=0.
  - Clears to 0 on p_gnt=1, or when p_req=0.
  - Never exceeds STARVE_LIMIT.
- After FORCE, wait_cnt=0, so at least STARVE_LIMIT CPU cycles pass before the next forced stall. The CPU is never stalled two consecutive cycles.
- Response routing: rd_owner is registered each cycle.
  - rd_owner=PERIPH when a peripheral read was granted.
  - rd_owner=CPU when a CPU read was issued.
  - rd_owner=NONE otherwise.
- p_rvalid is asserted for exactly one cycle, the cycle after a peripheral read grant, with p_rdata=ram_dataOut. p_rdata is combinationally routed while p_rvalid=1 and registered-held otherwise.
- No response is generated for peripheral writes.
- cpu_q=ram_dataOut unconditionally. The processor ignores it when its access was stalled.
- p_gnt is a single-cycle indication per beat. A requester holding p_req after a grant issues a new beat; back-to-back grants are allowed when cpu_access=0.
- stall_count increments on each FORCE cycle and saturates at all-ones.
- An async reset during an outstanding peripheral read discards the response: p_rvalid stays 0 after reset release.

Test Plan:
- CPU only: cpu_access=1, cpu_wren=1, addr 0x010, data 0xDEADBEEF, then read 0x010. Required: ram_wEn=1 in the write cycle; cpu_q=0xDEADBEEF one cycle after the read; cpu_stall=0 throughout.
- Peripheral idle-bus read: cpu_access=0, p_req=1, p_we=0, p_addr=0x010. Required: p_gnt=1 the same cycle; p_rvalid=1 with p_rdata=0xDEADBEEF the next cycle, for one cycle only.
- Starvation with STARVE_LIMIT=8: cpu_access=1 continuously, p_req=1 p_we=1 p_addr=0x020 p_wdata=0x12345678. Required:
  - p_gnt=0 for 8 cycles.
  - Cycle 9: p_gnt=1, cpu_stall=1, ram_addr=0x020.
  - stall_count=1; wait_cnt back to 0.
  - The next forced grant occurs no earlier than 8 cycles later.
- Collision: cpu_wren and p_we both asserted to 0x030 (CPU 0xAAAA0000, periph 0x0000BBBB), cpu_access drops the next cycle. Required: the CPU write issues first; the peripheral write issues the next cycle; a final read of 0x030 returns 0x0000BBBB.
- Reset mid-read: peripheral read granted, reset driven low before the next edge. Required: p_rvalid=0, p_gnt=0, ram_wEn=0, stall_count=0 immediately. After release with all inputs idle, no spurious p_rvalid.
- Saturation with STALL_CNT_W=2: force 5 starvation events. Required: stall_count reads 3 and holds.
